// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM states, sign helpers and the
// quotient returned on divide-by-zero. Helpers work at MAX_W bits; callers cast down.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  // Two's-complement low bits do not depend on high bits, so a wide helper
  // truncated to WIDTH gives the exact WIDTH-bit result (WIDTH <= MAX_W).
  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DIVZ_Q = '1;

  function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
    return ~x + MAX_W'(1);
  endfunction

  function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic neg);
    return neg ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, compare against
// the divisor and subtract when it fits, producing one quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign shifted = {rem_in, q_in[WIDTH-1]};
  assign ge      = shifted >= {1'b0, dvs};
  // When ge holds the true difference is below 2**WIDTH, so low bits suffice.
  assign diff    = shifted[WIDTH-1:0] - dvs;
  assign rem_out = ge ? diff : shifted[WIDTH-1:0];
  assign q_out   = {q_in[WIDTH-2:0], ge};

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned, cancelable.
// Optional macro DIVIDER_DIVZ_FLAG_EN adds the div_by_zero output.
module iter_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
`ifdef DIVIDER_DIVZ_FLAG_EN
  output logic             div_by_zero,
`endif
  output div_state_t       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshake: start is accepted on a rising edge only while IDLE (busy low);
  // done is a one-cycle pulse marking that quotient/remainder were just updated.

  div_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem, qsh, dvs, dvd_raw;
  logic [WIDTH-1:0] rem_step, q_step;
  logic             q_neg, r_neg, divz;
  logic             accept, finish;

  logic             dvd_sign, dvs_sign;
  logic [WIDTH-1:0] dvd_abs, dvs_abs, q_fix, r_fix;

  assign dvd_sign = is_signed & dividend[WIDTH-1];
  assign dvs_sign = is_signed & divisor[WIDTH-1];
  // |MIN| stays MIN as an unsigned value, which gives MIN/-1 = MIN with no trap.
  assign dvd_abs  = WIDTH'(abs_val(MAX_W'(dividend), dvd_sign));
  assign dvs_abs  = WIDTH'(abs_val(MAX_W'(divisor), dvs_sign));
  assign q_fix    = q_neg ? WIDTH'(negate(MAX_W'(qsh))) : qsh;
  assign r_fix    = r_neg ? WIDTH'(negate(MAX_W'(rem))) : rem;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem),
    .q_in    (qsh),
    .dvs     (dvs),
    .rem_out (rem_step),
    .q_out   (q_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          accept     = 1'b1;
        end
      end
      CALC: begin
        if (cancel)                           state_next = IDLE;
        else if (count == CNT_W'(WIDTH - 1))  state_next = FIX;
      end
      FIX: begin
        // cancel wins over completion in the same cycle
        state_next = IDLE;
        finish     = !cancel;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      rem       <= '0;
      qsh       <= '0;
      dvs       <= '0;
      dvd_raw   <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      divz      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        count   <= '0;
        rem     <= '0;
        qsh     <= dvd_abs;
        dvs     <= dvs_abs;
        dvd_raw <= dividend;
        q_neg   <= dvd_sign ^ dvs_sign;
        r_neg   <= dvd_sign;
        divz    <= (divisor == '0);
      end else if (state == CALC) begin
        rem   <= rem_step;
        qsh   <= q_step;
        count <= count + CNT_W'(1);
      end
      // divide-by-zero reports the raw dividend, not the sign-adjusted one
      if (finish) begin
        quotient  <= divz ? WIDTH'(DIVZ_Q) : q_fix;
        remainder <= divz ? dvd_raw : r_fix;
      end
    end
  end

`ifdef DIVIDER_DIVZ_FLAG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      div_by_zero <= 1'b0;
    else if (finish) div_by_zero <= divz;
  end
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider (WIDTH=32): hand-computed quotient/remainder,
// latency, cancel, reset and back-to-back issue. Honours DIVIDER_DIVZ_FLAG_EN.
module tb_iter_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   dbg_state;

  int total  = 0;
  int passed = 0;
  int lat;
  int busy_cnt;
  int done_seen;

  iter_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .cancel      (cancel),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
`ifdef DIVIDER_DIVZ_FLAG_EN
    .div_by_zero (div_by_zero),
`endif
    .dbg_state   (dbg_state)
  );

`ifndef DIVIDER_DIVZ_FLAG_EN
  assign div_by_zero = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns 1 time unit after the accepting posedge.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // lat = rising edges from accept to the negedge where done is first seen.
  task automatic wait_done(input string tag);
    lat      = 0;
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
      @(posedge clk);
      lat++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic op(input string tag, input logic sgn, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er);
    issue(sgn, a, b);
    wait_done(tag);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_lat"}, lat, W + 1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; cancel = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_state", dbg_state, 0);
    check("rst_divz", div_by_zero, 0);
    reset = 1'b1;
    @(negedge clk);

    // unsigned basic with latency and busy span (CALC + FIX cycles)
    issue(1'b0, 32'd30, 32'd7);
    wait_done("divu_30_7");
    check("divu_30_7_q", quotient, 32'd4);
    check("divu_30_7_r", remainder, 32'd2);
    check("divu_30_7_lat", lat, 33);
    check("divu_30_7_busy", busy_cnt, 33);
    check("divu_30_7_busy_at_done", busy, 0);

    op("div_m30_7", 1'b1, 32'hFFFF_FFE2, 32'd7, 32'hFFFF_FFFC, 32'hFFFF_FFFE);
    op("div_30_m7", 1'b1, 32'd30, 32'hFFFF_FFF9, 32'hFFFF_FFFC, 32'd2);
    op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    op("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);

    op("divu_30_0", 1'b0, 32'd30, 32'd0, 32'hFFFF_FFFF, 32'd30);
`ifdef DIVIDER_DIVZ_FLAG_EN
    check("divz_set", div_by_zero, 1);
`endif
    op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
`ifdef DIVIDER_DIVZ_FLAG_EN
    check("divz_clr", div_by_zero, 0);
`endif
    op("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

    // cancel mid-CALC: no done, outputs keep -5/0 results
    issue(1'b0, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    check("cancel_state_calc", dbg_state, 1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_done", done, 0);
    check("cancel_q", quotient, 32'hFFFF_FFFF);
    check("cancel_r", remainder, 32'hFFFF_FFFB);
`ifdef DIVIDER_DIVZ_FLAG_EN
    check("cancel_divz", div_by_zero, 1);
`endif
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("cancel_no_done", done_seen, 0);

    // start while busy must not disturb the in-flight op
    issue(1'b0, 32'd100, 32'd9);
    repeat (4) @(negedge clk);
    dividend = 32'd50; divisor = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start");
    check("busy_start_q", quotient, 32'd11);
    check("busy_start_r", remainder, 32'd1);
    check("busy_start_lat", lat, 28);

    // back-to-back: start issued in the done cycle
    issue(1'b0, 32'd7, 32'd2);
    wait_done("b2b_a");
    check("b2b_a_q", quotient, 32'd3);
    check("b2b_a_r", remainder, 32'd1);
    issue(1'b0, 32'd45, 32'd6);
    wait_done("b2b_b");
    check("b2b_b_q", quotient, 32'd7);
    check("b2b_b_r", remainder, 32'd3);
    check("b2b_b_lat", lat, 33);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // asynchronous reset mid-CALC
    issue(1'b0, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    op("post_rst", 1'b0, 32'd77, 32'd7, 32'd11, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
